// File: rtl/rptr_empty_fwft.sv
// Read-side controller of the async FIFO: write-pointer synchronizer, read pointers,
// empty/almost-empty/count flags and a two-entry first-word-fall-through output stage.
module rptr_empty_fwft #(
  parameter int unsigned ADDRSIZE  = 4,
  parameter int unsigned DATASIZE  = 32,
  parameter int unsigned AEMPTY_TH = 2
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [ADDRSIZE:0]   wptr_async,
  output logic [ADDRSIZE:0]   rptr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic                ren,
  input  logic [DATASIZE-1:0] mem_rdata,
  output logic                rempty,
  output logic [ADDRSIZE:0]   rcount,
  output logic                raempty,
  output logic                rvalid,
  output logic [DATASIZE-1:0] rdata,
  input  logic                rready
);

  localparam int unsigned PW = ADDRSIZE + 1;

  logic [PW-1:0]       s1;
  logic [PW-1:0]       wptr_rclk;
  logic [PW-1:0]       wbin_rclk;
  logic [PW-1:0]       rbin;
  logic [PW-1:0]       rbinnext;
  logic [PW-1:0]       rgraynext;
  logic [PW-1:0]       rcount_next;
  logic                inflight;
  logic                out_v;
  logic                skid_v;
  logic [DATASIZE-1:0] skid_q;
  logic                pop;
  logic [1:0]          occupancy;

  // Gray-to-binary of the synchronized write pointer
  always_comb begin
    wbin_rclk = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      wbin_rclk[i] = ^(wptr_rclk >> i);
    end
  end

  // Fetch decision: keep out+skid+in-flight at most two, refill on a pop
  always_comb begin
    pop         = out_v & rready;
    occupancy   = 2'(out_v) + 2'(skid_v) + 2'(inflight);
    ren         = ~rempty & ((occupancy < 2'd2) | pop);
    rbinnext    = rbin + PW'(ren);
    rgraynext   = (rbinnext >> 1) ^ rbinnext;
    rcount_next = wbin_rclk - rbinnext;
    raddr       = rbin[ADDRSIZE-1:0];
    rvalid      = out_v;
  end

  // Synchronizer, pointers and flags
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      s1        <= '0;
      wptr_rclk <= '0;
      rbin      <= '0;
      rptr      <= '0;
      rempty    <= 1'b1;
      rcount    <= '0;
      raempty   <= 1'b1;
      inflight  <= 1'b0;
    end else begin
      s1        <= wptr_async;
      wptr_rclk <= s1;
      rbin      <= rbinnext;
      rptr      <= rgraynext;
      rempty    <= (rgraynext == wptr_rclk);
      rcount    <= rcount_next;
      raempty   <= (rcount_next <= PW'(AEMPTY_TH));
      inflight  <= ren;
    end
  end

  // Output stage: out register feeds the consumer, skid absorbs the word behind it
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
      rdata  <= '0;
      skid_q <= '0;
    end else if (pop && skid_v) begin
      rdata  <= skid_q;
      skid_v <= inflight;
      if (inflight) begin
        skid_q <= mem_rdata;
      end
    end else if (pop) begin
      out_v <= inflight;
      if (inflight) begin
        rdata <= mem_rdata;
      end
    end else if (inflight) begin
      if (!out_v) begin
        out_v <= 1'b1;
        rdata <= mem_rdata;
      end else begin
        skid_v <= 1'b1;
        skid_q <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_rptr_empty_fwft.sv
// Bench for rptr_empty_fwft: models the write side and RAM, scoreboards the output stream.
module tb_rptr_empty_fwft;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned PW = AW + 1;
  localparam int unsigned NRAND = 10000;

  logic          rclk = 1'b0;
  logic          rrst_n;
  logic [PW-1:0] wptr_async;
  logic [PW-1:0] rptr;
  logic [AW-1:0] raddr;
  logic          ren;
  logic [DW-1:0] mem_rdata;
  logic          rempty;
  logic [PW-1:0] rcount;
  logic          raempty;
  logic          rvalid;
  logic [DW-1:0] rdata;
  logic          rready;

  rptr_empty_fwft #(.ADDRSIZE(AW), .DATASIZE(DW), .AEMPTY_TH(2)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .wptr_async(wptr_async), .rptr(rptr), .raddr(raddr),
    .ren(ren), .mem_rdata(mem_rdata), .rempty(rempty), .rcount(rcount), .raempty(raempty),
    .rvalid(rvalid), .rdata(rdata), .rready(rready)
  );

  always #5 rclk = ~rclk;

  logic [DW-1:0] ram [16];
  always @(posedge rclk) if (ren) mem_rdata <= ram[raddr];

  int unsigned   total = 0;
  int unsigned   bad = 0;
  int unsigned   ren_cnt = 0;
  int unsigned   pop_cnt = 0;
  logic [DW-1:0] exp_q [$];
  logic [PW-1:0] wbin;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = '0;
    for (int unsigned i = 0; i < PW; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  // Write-side model: RAM word first, then the Gray pointer
  task automatic push_word(input logic [DW-1:0] d);
    ram[wbin[AW-1:0]] = d;
    exp_q.push_back(d);
    wbin = wbin + PW'(1);
    wptr_async = wbin ^ (wbin >> 1);
  endtask

  // Monitor: pops and compares every accepted word, and polices ren while empty
  always @(negedge rclk) begin
    if (rrst_n) begin
      if (ren) ren_cnt++;
      if (rempty) chk("ren_when_empty", 64'(ren), 64'd0);
      if (rvalid && rready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pop_underflow: got %0h expected no word", rdata);
        end else begin
          chk("rdata_order", 64'(rdata), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    int unsigned   streak;
    int unsigned   rc0;
    int unsigned   seen;
    int unsigned   pushed;
    int unsigned   p0;
    logic [PW-1:0] used;

    rrst_n = 1'b0;
    rready = 1'b0;
    wptr_async = '0;
    wbin = '0;
    repeat (2) @(posedge rclk);
    #1;
    chk("rst_rempty", 64'(rempty), 64'd1);
    chk("rst_raempty", 64'(raempty), 64'd1);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rptr", 64'(rptr), 64'd0);
    chk("rst_rcount", 64'(rcount), 64'd0);
    chk("rst_ren", 64'(ren), 64'd0);
    chk("rst_raddr", 64'(raddr), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    rrst_n = 1'b1;
    tick();
    tick();

    // single word: pointer changes before E1, rvalid at E5
    push_word(32'h1111_0001);
    for (int e = 1; e <= 5; e++) begin
      tick();
      if (e == 3) begin
        chk("sw_rempty_e3", 64'(rempty), 64'd0);
        chk("sw_rcount_e3", 64'(rcount), 64'd1);
      end
      if (e == 4) begin
        chk("sw_rempty_e4", 64'(rempty), 64'd1);
        chk("sw_rptr_e4", 64'(rptr), 64'd1);
        chk("sw_rcount_e4", 64'(rcount), 64'd0);
      end
      chk("sw_rvalid", 64'(rvalid), (e == 5) ? 64'd1 : 64'd0);
    end
    chk("sw_rdata", 64'(rdata), 64'h1111_0001);
    rready = 1'b1;
    tick();
    tick();
    chk("sw_after_rvalid", 64'(rvalid), 64'd0);
    chk("sw_after_rempty", 64'(rempty), 64'd1);

    // stream of 16 words with rready held high, crossing the pointer wrap
    for (int k = 0; k < 16; k++) push_word(32'h2222_0000 + 32'(k));
    for (int k = 0; k < 20 && !rvalid; k++) tick();
    chk("stream_start", 64'(rvalid), 64'd1);
    streak = 0;
    while (rvalid && streak < 40) begin
      streak++;
      tick();
    end
    chk("stream_len", 64'(streak), 64'd16);
    chk("stream_rptr", 64'(rptr), 64'(5'b11001));
    chk("stream_rempty", 64'(rempty), 64'd1);
    chk("stream_rcount", 64'(rcount), 64'd0);

    // backpressure: only two RAM reads while rready is low
    rready = 1'b0;
    rc0 = ren_cnt;
    for (int k = 0; k < 8; k++) push_word(32'h3333_0000 + 32'(k));
    repeat (12) tick();
    chk("bp_reads", 64'(ren_cnt - rc0), 64'd2);
    chk("bp_rcount", 64'(rcount), 64'd6);
    chk("bp_rvalid", 64'(rvalid), 64'd1);
    for (int k = 0; k < 80 && exp_q.size() != 0; k++) begin
      rready = ~rready;
      tick();
    end
    rready = 1'b0;
    repeat (3) tick();
    chk("bp_drained", 64'(exp_q.size()), 64'd0);
    chk("bp_rempty", 64'(rempty), 64'd1);
    chk("bp_rcount_end", 64'(rcount), 64'd0);

    // almost-empty threshold
    for (int k = 0; k < 5; k++) push_word(32'h4444_0000 + 32'(k));
    repeat (3) tick();
    chk("ae_rcount5", 64'(rcount), 64'd5);
    chk("ae_raempty5", 64'(raempty), 64'd0);
    repeat (6) tick();
    chk("ae_rcount3", 64'(rcount), 64'd3);
    chk("ae_raempty3", 64'(raempty), 64'd0);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("ae_rcount2", 64'(rcount), 64'd2);
    chk("ae_raempty2", 64'(raempty), 64'd1);
    rready = 1'b1;
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick();
    rready = 1'b0;
    repeat (3) tick();
    chk("ae_drained", 64'(exp_q.size()), 64'd0);
    chk("ae_rcount0", 64'(rcount), 64'd0);
    chk("ae_raempty0", 64'(raempty), 64'd1);

    // asynchronous reset mid-burst
    rready = 1'b1;
    for (int k = 0; k < 8; k++) push_word(32'h5555_0000 + 32'(k));
    repeat (6) tick();
    #2;
    rrst_n = 1'b0;
    exp_q.delete();
    wbin = '0;
    wptr_async = '0;
    #1;
    chk("ar_rempty", 64'(rempty), 64'd1);
    chk("ar_rvalid", 64'(rvalid), 64'd0);
    chk("ar_rptr", 64'(rptr), 64'd0);
    chk("ar_rcount", 64'(rcount), 64'd0);
    tick();
    tick();
    rrst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      tick();
      if (rvalid) seen++;
    end
    chk("ar_no_stale", 64'(seen), 64'd0);

    // random writes and random rready
    pushed = 0;
    p0 = pop_cnt;
    for (int c = 0; c < 60000 && pushed < NRAND; c++) begin
      rready = ($urandom_range(0, 3) != 0);
      used = wbin - g2b(rptr);
      if ($urandom_range(0, 3) != 0 && used < PW'(16)) begin
        push_word($urandom);
        pushed++;
      end
      tick();
    end
    rready = 1'b1;
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) tick();
    rready = 1'b0;
    repeat (3) tick();
    chk("rnd_pushed", 64'(pushed), 64'(NRAND));
    chk("rnd_popped", 64'(pop_cnt - p0), 64'(NRAND));
    chk("rnd_drained", 64'(exp_q.size()), 64'd0);
    chk("rnd_rempty", 64'(rempty), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
